// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch responder: NOP encoding,
// default capacity and the fetch-state enum.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam int          DEPTH_LOG2_DEF = 10;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// Loader byte stream plus fetch request/response channel of the responder.
interface instr_fetch_responder_if;

    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;

    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;

    modport master (
        output ld_valid, ld_data, ld_last, req_valid, req_addr,
        input  ld_ready, req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  ld_valid, ld_data, ld_last, req_valid, req_addr,
        output ld_ready, req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/instr_ram.sv
// Instruction word store: one synchronous write port, one synchronous read port.
module instr_ram
    import cpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [31:0]           wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [31:0]           rdata
);

    logic [31:0] mem [2**DEPTH_LOG2];

    // Contents are intentionally never reset so an image survives reload.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/instr_fetch_responder.sv
// Loads a little-endian byte image into instruction RAM, then serves
// single-cycle-latency instruction fetches from it.
//
//   state | meaning
//   LOAD  | accepting loader bytes, fetch channel stalled
//   RUN   | image loaded, serving fetch requests
module instr_fetch_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
    input  logic                     clk,
    input  logic                     rstn,
    instr_fetch_responder_if.slave   bus,
    input  logic                     reload,
    output logic                     load_done,
    output logic                     load_ovf
);

    localparam int            AW   = DEPTH_LOG2 + 1;
    localparam logic [AW-1:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    fetch_state_e state, state_nxt;

    logic [1:0]    byte_cnt;
    logic [AW-1:0] waddr;
    logic [23:0]   word_buf;
    logic [31:0]   wdata;
    logic [31:0]   ram_rdata;
    logic          ld_acc, req_acc, full, we, addr_ok;
    logic          rsp_valid_q, rsp_err_q;

    assign ld_acc  = bus.ld_valid  && (state == LOAD);
    assign req_acc = bus.req_valid && (state == RUN);

    always_ff @(posedge clk) begin
        if (!rstn) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        bus.ld_ready  = 1'b0;
        bus.req_ready = 1'b0;
        load_done     = 1'b0;
        case (state)
            LOAD: begin
                bus.ld_ready = 1'b1;
                if (ld_acc && bus.ld_last) state_nxt = RUN;
            end
            RUN: begin
                bus.req_ready = 1'b1;
                load_done     = 1'b1;
                if (reload) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    // Bytes above the current position are zero, which also gives the
    // zero-fill for a short final word.
    always_comb begin
        wdata = 32'h0;
        case (byte_cnt)
            2'd0:    wdata = {24'h0, bus.ld_data};
            2'd1:    wdata = {16'h0, bus.ld_data, word_buf[7:0]};
            2'd2:    wdata = {8'h0,  bus.ld_data, word_buf[15:0]};
            default: wdata = {bus.ld_data, word_buf};
        endcase
    end

    assign full = (waddr == FULL);
    assign we   = ld_acc && !full && ((byte_cnt == 2'd3) || bus.ld_last);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            byte_cnt <= 2'd0;
            waddr    <= '0;
            word_buf <= 24'h0;
            load_ovf <= 1'b0;
        end else if (state == RUN) begin
            if (reload) begin
                byte_cnt <= 2'd0;
                waddr    <= '0;
                load_ovf <= 1'b0;
            end
        end else if (ld_acc) begin
            if (full) begin
                load_ovf <= 1'b1;
            end else begin
                word_buf <= wdata[23:0];
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) waddr <= waddr + AW'(1);
            end
            if (bus.ld_last) begin
                byte_cnt <= 2'd0;
                waddr    <= '0;
            end
        end
    end

    assign addr_ok = (bus.req_addr[1:0] == 2'b00) &&
                     (bus.req_addr[31:DEPTH_LOG2+2] == '0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= req_acc;
            rsp_err_q   <= req_acc && !addr_ok;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = !rsp_valid_q ? 32'h0 :
                           rsp_err_q    ? NOP_INSTR : ram_rdata;

    instr_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr[DEPTH_LOG2-1:0]),
        .wdata (wdata),
        .re    (req_acc && addr_ok),
        .raddr (bus.req_addr[DEPTH_LOG2+1:2]),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Directed bench for instr_fetch_responder with a byte-image model checked every cycle.
module tb_instr_fetch_responder;
    import cpu_pkg::*;

    localparam int D     = 10;
    localparam int WORDS = 1 << D;

    logic clk    = 1'b0;
    logic rstn   = 1'b0;
    logic reload = 1'b0;
    logic load_done, load_ovf;

    instr_fetch_responder_if bus();

    instr_fetch_responder #(.DEPTH_LOG2(D)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bus       (bus),
        .reload    (reload),
        .load_done (load_done),
        .load_ovf  (load_ovf)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: image as a byte stream, committed to words of four (or padded on last).
    logic [31:0] m_mem   [WORDS];
    bit          m_known [WORDS];
    logic [7:0]  pend[$];
    logic [31:0] m_w;
    int          m_words = 0;
    bit          m_run = 0, m_ovf = 0, chk_en = 0;
    bit          e_valid = 0, e_err = 0, e_known = 0;
    logic [31:0] e_data = 0;

    always @(posedge clk) begin
        e_valid = 0; e_err = 0; e_known = 0; e_data = 0;
        if (!rstn) begin
            m_run = 0; m_ovf = 0; m_words = 0; pend.delete();
        end else if (m_run) begin
            if (bus.req_valid) begin
                e_valid = 1;
                if ((bus.req_addr % 4) != 0 || bus.req_addr >= 32'(4 * WORDS)) begin
                    e_err = 1; e_data = NOP_INSTR; e_known = 1;
                end else begin
                    e_data  = m_mem[int'(bus.req_addr >> 2)];
                    e_known = m_known[int'(bus.req_addr >> 2)];
                end
            end
            if (reload) begin
                m_run = 0; m_words = 0; m_ovf = 0; pend.delete();
            end
        end else if (bus.ld_valid) begin
            if (m_words >= WORDS) m_ovf = 1;
            else pend.push_back(bus.ld_data);
            if (pend.size() == 4 || (bus.ld_last && pend.size() != 0)) begin
                m_w = 32'h0;
                for (int i = 0; i < pend.size(); i++) m_w[8*i +: 8] = pend[i];
                m_mem[m_words] = m_w; m_known[m_words] = 1;
                m_words++;
                pend.delete();
            end
            if (bus.ld_last) begin
                m_run = 1; m_words = 0; pend.delete();
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("ld_ready",  bus.ld_ready,  !m_run);
            check("req_ready", bus.req_ready, m_run);
            check("load_done", load_done,     m_run);
            check("load_ovf",  load_ovf,      m_ovf);
            check("rsp_valid", bus.rsp_valid, e_valid);
            if (e_valid) begin
                check("rsp_err", bus.rsp_err, e_err);
                if (e_known) check("rsp_data", bus.rsp_data, e_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] d, input bit last);
        bus.ld_valid = 1; bus.ld_data = d; bus.ld_last = last;
        tick();
        bus.ld_valid = 0; bus.ld_last = 0;
    endtask

    task automatic fetch_chk(input string name, input logic [31:0] a,
                             input logic [31:0] exp_d, input bit exp_e);
        bus.req_valid = 1; bus.req_addr = a;
        tick();
        bus.req_valid = 0;
        @(negedge clk);
        check({name, "_valid"}, bus.rsp_valid, 1);
        check({name, "_data"},  bus.rsp_data,  exp_d);
        check({name, "_err"},   bus.rsp_err,   exp_e);
        tick();
    endtask

    initial begin
        bus.ld_valid = 0; bus.ld_data = 0; bus.ld_last = 0;
        bus.req_valid = 0; bus.req_addr = 0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data",  bus.rsp_data,  0);
        check("rst_rsp_err",   bus.rsp_err,   0);
        check("rst_load_done", load_done,     0);
        check("rst_ld_ready",  bus.ld_ready,  1);
        check("rst_load_ovf",  load_ovf,      0);
        tick();
        rstn = 1; chk_en = 1;

        // First image: one full word.
        send(8'h13, 0); send(8'h05, 0); send(8'h10, 0); send(8'h00, 1);
        check("img1_done", load_done, 1);
        fetch_chk("img1_w0", 32'h0, 32'h0010_0513, 0);

        // Reload, ignored reload in LOAD, then a 6-byte image with a short tail.
        reload = 1; tick(); reload = 0;
        check("reload_done", load_done, 0);
        reload = 1; tick(); reload = 0;
        check("reload_in_load", bus.ld_ready, 1);
        send(8'h93, 0); send(8'h00, 0); send(8'h50, 0); send(8'h00, 0);
        send(8'hAA, 0); send(8'hBB, 1);
        fetch_chk("img2_w1", 32'h4, 32'h0000_BBAA, 0);
        fetch_chk("img2_w0", 32'h0, 32'h0050_0093, 0);

        fetch_chk("misalign", 32'h2,         NOP_INSTR, 1);
        fetch_chk("range",    32'h0000_1000, NOP_INSTR, 1);

        // Overflow: 4097 bytes, byte k carries k[7:0].
        reload = 1; tick(); reload = 0;
        for (int k = 1; k <= 4097; k++) send(8'(k), k == 4097);
        check("ovf_flag", load_ovf,  1);
        check("ovf_run",  load_done, 1);
        fetch_chk("ovf_last_word", 32'd4092, 32'h00FF_FEFD, 0);

        // Back-to-back fetches 0,4,8.
        bus.req_valid = 1; bus.req_addr = 32'h0;
        tick(); bus.req_addr = 32'h4;
        @(negedge clk); check("b2b_0", bus.rsp_data, 32'h0403_0201);
        tick(); bus.req_addr = 32'h8;
        @(negedge clk); check("b2b_4", bus.rsp_data, 32'h0807_0605);
        tick(); bus.req_valid = 0;
        @(negedge clk); check("b2b_8", bus.rsp_data, 32'h0C0B_0A09);
        check("b2b_8_valid", bus.rsp_valid, 1);
        tick();

        // Reload with a fetch in flight: response still delivered.
        bus.req_valid = 1; bus.req_addr = 32'h8; reload = 1;
        tick(); bus.req_valid = 0; reload = 0;
        @(negedge clk);
        check("inflight_valid", bus.rsp_valid, 1);
        check("inflight_data",  bus.rsp_data,  32'h0C0B_0A09);
        check("inflight_done",  load_done,     0);
        check("inflight_ovf",   load_ovf,      0);
        tick();

        // Reset mid-word discards the partial word.
        send(8'h11, 0); send(8'h22, 0);
        rstn = 0; tick(); rstn = 1;
        send(8'hDE, 0); send(8'hAD, 0); send(8'hBE, 0); send(8'hEF, 1);
        fetch_chk("rst_w0",     32'h0, 32'hEFBE_ADDE, 0);
        fetch_chk("persist_w1", 32'h4, 32'h0807_0605, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
